// File: rtl/aximm_csr_avmm_slave.sv
// -----------------------------------------------------------------------------
// aximm_csr_avmm_slave
// Avalon-MM CSR slave for the M2S channel of the AXI-MM GPIO test controller.
// Holds the test configuration (base address, write/read launch words, delay
// X/Y/Z), reports link/bus status with sticky done flags, and exposes the
// first/last data beats captured by the traffic engine. Reads return with a
// fixed two-cycle latency.
//
// Ports
//   avmm_clk, avmm_rst        clock, synchronous active-high reset
//   i_wr_addr                 byte address shared by reads and writes
//   i_wrdata                  write data
//   i_wren, i_rden            request levels; only rising edges are accepted
//   o_master_readdata         read data, valid with o_master_readdatavalid
//   o_master_readdatavalid    one-cycle read-return strobe
//   o_master_waitrequest      high while a read is outstanding
//   o_wr_start, o_rd_start    one-cycle launch pulses on WR_CFG / RD_CFG writes
//   o_wr_cfg, o_rd_cfg        last values written to WR_CFG / RD_CFG
//   o_axi_addr                WR_RD_ADDR register
//   o_delay_x/_y/_z           delay registers
//   i_linkup, i_sts           live status levels
//   i_wr_done, i_rd_done      burst-complete pulses (set the sticky flags)
//   i_dout_first/_last        first/last beat sent
//   i_din_first/_last         first/last beat received
// -----------------------------------------------------------------------------
module aximm_csr_avmm_slave #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter logic [31:0] ADDR_BASE  = 32'h5000_0000
) (
  input  logic                  avmm_clk,
  input  logic                  avmm_rst,
  input  logic [31:0]           i_wr_addr,
  input  logic [31:0]           i_wrdata,
  input  logic                  i_wren,
  input  logic                  i_rden,
  output logic [31:0]           o_master_readdata,
  output logic                  o_master_readdatavalid,
  output logic                  o_master_waitrequest,
  output logic                  o_wr_start,
  output logic                  o_rd_start,
  output logic [31:0]           o_wr_cfg,
  output logic [31:0]           o_rd_cfg,
  output logic [31:0]           o_axi_addr,
  output logic [7:0]            o_delay_x,
  output logic [7:0]            o_delay_y,
  output logic [15:0]           o_delay_z,
  input  logic [3:0]            i_linkup,
  input  logic [3:0]            i_sts,
  input  logic                  i_wr_done,
  input  logic                  i_rd_done,
  input  logic [DATA_WIDTH-1:0] i_dout_first,
  input  logic [DATA_WIDTH-1:0] i_dout_last,
  input  logic [DATA_WIDTH-1:0] i_din_first,
  input  logic [DATA_WIDTH-1:0] i_din_last
);

  localparam int unsigned NUM_WORDS = DATA_WIDTH / 32;
  localparam int unsigned OFF_W     = 16;

  localparam logic [OFF_W-1:0] OFF_WR_CFG     = 16'h1000;
  localparam logic [OFF_W-1:0] OFF_WR_RD_ADDR = 16'h1004;
  localparam logic [OFF_W-1:0] OFF_BUS_STS    = 16'h1008;
  localparam logic [OFF_W-1:0] OFF_LINKUP_STS = 16'h100C;
  localparam logic [OFF_W-1:0] OFF_RD_CFG     = 16'h1010;
  localparam logic [OFF_W-1:0] OFF_DELAY_X    = 16'h2000;
  localparam logic [OFF_W-1:0] OFF_DELAY_Y    = 16'h2004;
  localparam logic [OFF_W-1:0] OFF_DELAY_Z    = 16'h2008;
  localparam logic [OFF_W-1:0] OFF_DOUT_FIRST = 16'h4000;
  localparam logic [OFF_W-1:0] OFF_DOUT_LAST  = 16'h4010;
  localparam logic [OFF_W-1:0] OFF_DIN_FIRST  = 16'h4020;
  localparam logic [OFF_W-1:0] OFF_DIN_LAST   = 16'h4030;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2
  } rd_state_t;

  // Configuration / status registers
  logic [31:0]      r_wr_cfg;
  logic [31:0]      r_rd_cfg;
  logic [31:0]      r_axi_addr;
  logic [7:0]       r_delay_x;
  logic [7:0]       r_delay_y;
  logic [15:0]      r_delay_z;
  logic             r_wr_start;
  logic             r_rd_start;
  logic             r_wr_sticky;
  logic             r_rd_sticky;
  logic             r_wren_d;

  // Read path registers
  rd_state_t        r_state;
  logic             r_rden_d;
  logic [OFF_W-1:0] r_rd_addr;
  logic             r_rd_hit;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic             r_wait;

  // Request decode
  logic             w_hit;
  logic [OFF_W-1:0] w_off;
  logic             w_wr_edge;
  logic             w_rd_edge;
  logic             w_wr_go;
  logic             w_rd_acc;
  logic             w_clr_wr_sticky;
  logic             w_clr_rd_sticky;
  logic [31:0]      w_data_word;
  logic [31:0]      w_rd_mux;

  // Address window check; ADDR_BASE is 64 KB aligned so the low half is the offset
  assign w_hit = (i_wr_addr[31:16] == ADDR_BASE[31:16]);
  assign w_off = i_wr_addr[OFF_W-1:0];

  assign w_wr_edge = i_wren & ~r_wren_d;
  assign w_rd_edge = i_rden & ~r_rden_d;

  // Writes to undecoded space are dropped; a read edge coinciding with a write edge is dropped
  assign w_wr_go  = w_wr_edge & w_hit;
  assign w_rd_acc = w_rd_edge & ~w_wr_edge & (r_state == ST_IDLE);

  assign w_clr_wr_sticky = w_wr_go & (w_off == OFF_WR_CFG);
  assign w_clr_rd_sticky = w_wr_go & (w_off == OFF_RD_CFG);

  // Write path: register updates, launch pulses and sticky done flags
  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      r_wren_d    <= 1'b0;
      r_wr_cfg    <= '0;
      r_rd_cfg    <= '0;
      r_axi_addr  <= '0;
      r_delay_x   <= '0;
      r_delay_y   <= '0;
      r_delay_z   <= '0;
      r_wr_start  <= 1'b0;
      r_rd_start  <= 1'b0;
      r_wr_sticky <= 1'b0;
      r_rd_sticky <= 1'b0;
    end else begin
      r_wren_d   <= i_wren;
      r_wr_start <= w_clr_wr_sticky;
      r_rd_start <= w_clr_rd_sticky;

      if (w_wr_go) begin
        case (w_off)
          OFF_WR_CFG:     r_wr_cfg   <= i_wrdata;
          OFF_WR_RD_ADDR: r_axi_addr <= i_wrdata;
          OFF_RD_CFG:     r_rd_cfg   <= i_wrdata;
          OFF_DELAY_X:    r_delay_x  <= i_wrdata[7:0];
          OFF_DELAY_Y:    r_delay_y  <= i_wrdata[7:0];
          OFF_DELAY_Z:    r_delay_z  <= i_wrdata[15:0];
          default:        ;
        endcase
      end

      // Clear has priority over a same-cycle done pulse
      if (w_clr_wr_sticky) begin
        r_wr_sticky <= 1'b0;
      end else if (i_wr_done) begin
        r_wr_sticky <= 1'b1;
      end

      if (w_clr_rd_sticky) begin
        r_rd_sticky <= 1'b0;
      end else if (i_rd_done) begin
        r_rd_sticky <= 1'b1;
      end
    end
  end

  // Captured-beat window: each region is NUM_WORDS words, low word at the lowest address
  always_comb begin
    w_data_word = '0;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      if (r_rd_addr == OFF_DOUT_FIRST + OFF_W'(4 * k)) begin
        w_data_word = i_dout_first[32*k +: 32];
      end
      if (r_rd_addr == OFF_DOUT_LAST + OFF_W'(4 * k)) begin
        w_data_word = i_dout_last[32*k +: 32];
      end
      if (r_rd_addr == OFF_DIN_FIRST + OFF_W'(4 * k)) begin
        w_data_word = i_din_first[32*k +: 32];
      end
      if (r_rd_addr == OFF_DIN_LAST + OFF_W'(4 * k)) begin
        w_data_word = i_din_last[32*k +: 32];
      end
    end
  end

  // Read mux over the latched address; undecoded offsets fall through to the beat window, which defaults to 0
  always_comb begin
    w_rd_mux = '0;
    if (r_rd_hit) begin
      case (r_rd_addr)
        OFF_WR_CFG:     w_rd_mux = r_wr_cfg;
        OFF_WR_RD_ADDR: w_rd_mux = r_axi_addr;
        OFF_BUS_STS:    w_rd_mux = {26'd0, r_rd_sticky, r_wr_sticky, i_sts};
        OFF_LINKUP_STS: w_rd_mux = {28'd0, i_linkup};
        OFF_RD_CFG:     w_rd_mux = r_rd_cfg;
        OFF_DELAY_X:    w_rd_mux = {24'd0, r_delay_x};
        OFF_DELAY_Y:    w_rd_mux = {24'd0, r_delay_y};
        OFF_DELAY_Z:    w_rd_mux = {16'd0, r_delay_z};
        default:        w_rd_mux = w_data_word;
      endcase
    end
  end

  // Read FSM: IDLE -> DECODE (sample mux) -> RESP (strobe valid) -> IDLE
  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      r_state   <= ST_IDLE;
      r_rden_d  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_hit  <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_wait    <= 1'b0;
    end else begin
      r_rden_d <= i_rden;
      case (r_state)
        ST_IDLE: begin
          r_rvalid <= 1'b0;
          if (w_rd_acc) begin
            r_rd_addr <= w_off;
            r_rd_hit  <= w_hit;
            r_wait    <= 1'b1;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_rdata  <= w_rd_mux;
          r_rvalid <= 1'b1;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          r_rvalid <= 1'b0;
          r_wait   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_rvalid <= 1'b0;
          r_wait   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_master_readdata      = r_rdata;
  assign o_master_readdatavalid = r_rvalid;
  assign o_master_waitrequest   = r_wait;
  assign o_wr_start             = r_wr_start;
  assign o_rd_start             = r_rd_start;
  assign o_wr_cfg               = r_wr_cfg;
  assign o_rd_cfg               = r_rd_cfg;
  assign o_axi_addr             = r_axi_addr;
  assign o_delay_x              = r_delay_x;
  assign o_delay_y              = r_delay_y;
  assign o_delay_z              = r_delay_z;

endmodule

// File: tb/tb_aximm_csr_avmm_slave.sv
// -----------------------------------------------------------------------------
// tb_aximm_csr_avmm_slave
// Self-checking bench: directed vector table, hand-written multi-cycle corner
// sequences, then randomized traffic checked against a register-map model.
// Inputs are driven 1 ns after the rising edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_aximm_csr_avmm_slave;

  localparam int unsigned DW   = 128;
  localparam logic [31:0] BASE = 32'h5000_0000;

  logic          avmm_clk = 1'b0;
  logic          avmm_rst;
  logic [31:0]   i_wr_addr;
  logic [31:0]   i_wrdata;
  logic          i_wren;
  logic          i_rden;
  logic [31:0]   o_master_readdata;
  logic          o_master_readdatavalid;
  logic          o_master_waitrequest;
  logic          o_wr_start;
  logic          o_rd_start;
  logic [31:0]   o_wr_cfg;
  logic [31:0]   o_rd_cfg;
  logic [31:0]   o_axi_addr;
  logic [7:0]    o_delay_x;
  logic [7:0]    o_delay_y;
  logic [15:0]   o_delay_z;
  logic [3:0]    i_linkup;
  logic [3:0]    i_sts;
  logic          i_wr_done;
  logic          i_rd_done;
  logic [DW-1:0] i_dout_first;
  logic [DW-1:0] i_dout_last;
  logic [DW-1:0] i_din_first;
  logic [DW-1:0] i_din_last;

  aximm_csr_avmm_slave #(.DATA_WIDTH(DW), .ADDR_BASE(BASE)) dut (
    .avmm_clk               (avmm_clk),
    .avmm_rst               (avmm_rst),
    .i_wr_addr              (i_wr_addr),
    .i_wrdata               (i_wrdata),
    .i_wren                 (i_wren),
    .i_rden                 (i_rden),
    .o_master_readdata      (o_master_readdata),
    .o_master_readdatavalid (o_master_readdatavalid),
    .o_master_waitrequest   (o_master_waitrequest),
    .o_wr_start             (o_wr_start),
    .o_rd_start             (o_rd_start),
    .o_wr_cfg               (o_wr_cfg),
    .o_rd_cfg               (o_rd_cfg),
    .o_axi_addr             (o_axi_addr),
    .o_delay_x              (o_delay_x),
    .o_delay_y              (o_delay_y),
    .o_delay_z              (o_delay_z),
    .i_linkup               (i_linkup),
    .i_sts                  (i_sts),
    .i_wr_done              (i_wr_done),
    .i_rd_done              (i_rd_done),
    .i_dout_first           (i_dout_first),
    .i_dout_last            (i_dout_last),
    .i_din_first            (i_din_first),
    .i_din_last             (i_din_last)
  );

  always #5 avmm_clk = ~avmm_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model of the register file
  logic [31:0] m_wr_cfg, m_rd_cfg, m_axi_addr;
  logic [7:0]  m_dx, m_dy;
  logic [15:0] m_dz;
  logic        m_ws, m_rs;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge avmm_clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr_cfg = '0; m_rd_cfg = '0; m_axi_addr = '0;
    m_dx = '0; m_dy = '0; m_dz = '0;
    m_ws = 1'b0; m_rs = 1'b0;
  endtask

  // Applies one accepted write plus any done pulses in the same cycle; returns expected launch pulses
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic wd, input logic rd,
                             output logic ws_pulse, output logic rs_pulse);
    logic [31:0] off;
    off = addr - BASE;
    ws_pulse = 1'b0;
    rs_pulse = 1'b0;
    if (off < 32'h1_0000) begin
      case (off)
        32'h1000: begin m_wr_cfg = data; ws_pulse = 1'b1; end
        32'h1004: m_axi_addr = data;
        32'h1010: begin m_rd_cfg = data; rs_pulse = 1'b1; end
        32'h2000: m_dx = data[7:0];
        32'h2004: m_dy = data[7:0];
        32'h2008: m_dz = data[15:0];
        default: ;
      endcase
    end
    m_ws = ws_pulse ? 1'b0 : (m_ws | wd);
    m_rs = rs_pulse ? 1'b0 : (m_rs | rd);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] off;
    logic [DW-1:0] beat;
    int region, word;
    off = addr - BASE;
    if (off >= 32'h1_0000) return 32'h0;
    case (off)
      32'h1000: return m_wr_cfg;
      32'h1004: return m_axi_addr;
      32'h1008: return {26'd0, m_rs, m_ws, i_sts};
      32'h100C: return {28'd0, i_linkup};
      32'h1010: return m_rd_cfg;
      32'h2000: return {24'd0, m_dx};
      32'h2004: return {24'd0, m_dy};
      32'h2008: return {16'd0, m_dz};
      default: ;
    endcase
    if (off >= 32'h4000 && off < 32'h4040 && (off % 4) == 0) begin
      region = int'((off - 32'h4000) / 16);
      word   = int'(((off - 32'h4000) % 16) / 4);
      case (region)
        0:       beat = i_dout_first;
        1:       beat = i_dout_last;
        2:       beat = i_din_first;
        default: beat = i_din_last;
      endcase
      return beat[word*32 +: 32];
    end
    return 32'h0;
  endfunction

  task automatic check_cfg(input string name);
    check({name, "/wr_cfg"},  o_wr_cfg,   m_wr_cfg);
    check({name, "/rd_cfg"},  o_rd_cfg,   m_rd_cfg);
    check({name, "/axi_addr"}, o_axi_addr, m_axi_addr);
    check({name, "/dx"}, {24'd0, o_delay_x}, {24'd0, m_dx});
    check({name, "/dy"}, {24'd0, o_delay_y}, {24'd0, m_dy});
    check({name, "/dz"}, {16'd0, o_delay_z}, {16'd0, m_dz});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/rvalid"}, {31'd0, o_master_readdatavalid}, 32'd0);
    check({name, "/wait"},   {31'd0, o_master_waitrequest},   32'd0);
    check({name, "/rdata"},  o_master_readdata, 32'd0);
    check({name, "/wr_start"}, {31'd0, o_wr_start}, 32'd0);
    check({name, "/rd_start"}, {31'd0, o_rd_start}, 32'd0);
    check({name, "/wr_cfg"},  o_wr_cfg,   32'd0);
    check({name, "/rd_cfg"},  o_rd_cfg,   32'd0);
    check({name, "/axi_addr"}, o_axi_addr, 32'd0);
    check({name, "/delays"}, {o_delay_z, o_delay_y, o_delay_x}, 32'd0);
  endtask

  // Single-cycle write edge, with optional done pulses in the same cycle
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic wd, input logic rd, input string name);
    logic ws, rs;
    i_wr_addr = addr; i_wrdata = data; i_wren = 1'b1;
    i_wr_done = wd; i_rd_done = rd;
    model_write(addr, data, wd, rd, ws, rs);
    tick();
    i_wren = 1'b0; i_wr_done = 1'b0; i_rd_done = 1'b0;
    check({name, "/wr_start"}, {31'd0, o_wr_start}, {31'd0, ws});
    check({name, "/rd_start"}, {31'd0, o_rd_start}, {31'd0, rs});
    check_cfg(name);
    tick();
    check({name, "/start_end"}, {30'd0, o_wr_start, o_rd_start}, 32'd0);
  endtask

  // Read edge at cycle N; checks waitrequest/valid at N+1, N+2 and N+3
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    i_wr_addr = addr; i_rden = 1'b1;
    tick();
    i_rden = 1'b0;
    check({name, "/n1_wait_valid"}, {30'd0, o_master_waitrequest, o_master_readdatavalid}, 32'd2);
    tick();
    check({name, "/n2_wait_valid"}, {30'd0, o_master_waitrequest, o_master_readdatavalid}, 32'd3);
    check({name, "/data"}, o_master_readdata, exp);
    tick();
    check({name, "/n3_wait_valid"}, {30'd0, o_master_waitrequest, o_master_readdatavalid}, 32'd0);
  endtask

  task automatic pulse_done(input logic wd, input logic rd);
    i_wr_done = wd; i_rd_done = rd;
    tick();
    i_wr_done = 1'b0; i_rd_done = 1'b0;
    m_ws = m_ws | wd;
    m_rs = m_rs | rd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return BASE + 32'h1000 + 32'(4 * $urandom_range(0, 4));
      1:       return BASE + 32'h2000 + 32'(4 * $urandom_range(0, 2));
      2:       return BASE + 32'h4000 + 32'(4 * $urandom_range(0, 15));
      3:       return BASE + 32'($urandom_range(0, 32'hFFFF));
      4:       return BASE + 32'h1_0000 + 32'h1000 + 32'(4 * $urandom_range(0, 4));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int pulses;
    int nval;
    logic [31:0] exp_old;

    avmm_rst = 1'b1;
    i_wr_addr = '0; i_wrdata = '0; i_wren = 1'b0; i_rden = 1'b0;
    i_linkup = '0; i_sts = '0; i_wr_done = 1'b0; i_rd_done = 1'b0;
    i_dout_first = '0; i_dout_last = '0; i_din_first = '0; i_din_last = '0;
    model_reset();
    tick(); tick(); tick();
    check_all_zero("reset");
    avmm_rst = 1'b0;
    tick();

    // Directed vectors: write then read back
    tbl[0]  = '{BASE + 32'h2000, 32'h0000_000C, 32'h0000_000C};
    tbl[1]  = '{BASE + 32'h2004, 32'h0000_0020, 32'h0000_0020};
    tbl[2]  = '{BASE + 32'h2008, 32'h0000_1770, 32'h0000_1770};
    tbl[3]  = '{BASE + 32'h1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[4]  = '{BASE + 32'h1010, 32'h0000_0007, 32'h0000_0007};
    tbl[5]  = '{BASE + 32'h2000, 32'hFFFF_FFA5, 32'h0000_00A5};
    tbl[6]  = '{BASE + 32'h2008, 32'hABCD_1234, 32'h0000_1234};
    tbl[7]  = '{BASE + 32'h1008, 32'hFFFF_FFFF, 32'h0000_0005};
    tbl[8]  = '{BASE + 32'h100C, 32'hFFFF_FFFF, 32'h0000_000A};
    tbl[9]  = '{BASE + 32'h3000, 32'h1234_5678, 32'h0000_0000};
    tbl[10] = '{32'h6000_2000,   32'h0000_0099, 32'h0000_0000};
    tbl[11] = '{BASE + 32'h1000, 32'h1111_1111, 32'h1111_1111};
    i_sts = 4'h5; i_linkup = 4'hA;
    for (int i = 0; i < 12; i++) begin
      do_write(tbl[i].addr, tbl[i].wdata, 1'b0, 1'b0, $sformatf("tbl%0d_wr", i));
      do_read(tbl[i].addr, tbl[i].exp_rd, $sformatf("tbl%0d_rd", i));
    end

    // WR_CFG write held for three cycles gives one pulse and clears the write sticky
    pulse_done(1'b1, 1'b0);
    i_wr_addr = BASE + 32'h1000; i_wrdata = 32'h0004_1804; i_wren = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 2) i_wren = 1'b0;
      if (o_wr_start) pulses++;
    end
    m_wr_cfg = 32'h0004_1804; m_ws = 1'b0;
    check("hold_wren/pulses", 32'(pulses), 32'd1);
    check("hold_wren/wr_cfg", o_wr_cfg, 32'h0004_1804);
    i_sts = 4'h0;
    do_read(BASE + 32'h1008, 32'h0000_0000, "hold_wren/bus_sts");

    // Sticky flags, including clear-wins on a same-cycle done pulse
    pulse_done(1'b1, 1'b0);
    i_sts = 4'hF;
    do_read(BASE + 32'h1008, 32'h0000_001F, "sticky/wr_done");
    do_write(BASE + 32'h1010, 32'h0000_0042, 1'b0, 1'b1, "sticky/rd_clr_wr");
    do_read(BASE + 32'h1008, 32'h0000_001F, "sticky/clear_wins");
    pulse_done(1'b0, 1'b1);
    do_read(BASE + 32'h1008, 32'h0000_003F, "sticky/rd_done");

    // Captured last beat, low word first
    i_dout_last = 128'h01234567_DEADBEEF_CAFEF00D_89ABCDEF;
    do_read(BASE + 32'h4010, 32'h89AB_CDEF, "dout_last/w0");
    do_read(BASE + 32'h4014, 32'hCAFE_F00D, "dout_last/w1");
    do_read(BASE + 32'h4018, 32'hDEAD_BEEF, "dout_last/w2");
    do_read(BASE + 32'h401C, 32'h0123_4567, "dout_last/w3");

    // A fresh read edge arriving while the first read is still outstanding is dropped
    i_wr_addr = BASE + 32'h2000; i_rden = 1'b1;
    tick();
    i_rden = 1'b0;
    tick();
    nval = o_master_readdatavalid ? 1 : 0;
    i_rden = 1'b1;
    tick();
    i_rden = 1'b0;
    if (o_master_readdatavalid) nval++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_master_readdatavalid) nval++;
    end
    check("busy_edge/valid_count", 32'(nval), 32'd1);
    do_read(BASE + 32'h3000, 32'h0, "undecoded_read");

    // Write accepted during DECODE: read returns the pre-write value
    exp_old = model_read(BASE + 32'h2000);
    i_wr_addr = BASE + 32'h2000; i_rden = 1'b1;
    tick();
    i_rden = 1'b0; i_wren = 1'b1; i_wrdata = 32'h0000_005A;
    tick();
    i_wren = 1'b0;
    m_dx = 8'h5A;
    check("wr_during_rd/valid", {31'd0, o_master_readdatavalid}, 32'd1);
    check("wr_during_rd/data", o_master_readdata, exp_old);
    check("wr_during_rd/dx", {24'd0, o_delay_x}, 32'h5A);
    tick();

    // Simultaneous write and read edges: write lands, read never returns
    i_wr_addr = BASE + 32'h2004; i_wrdata = 32'h0000_0077; i_wren = 1'b1; i_rden = 1'b1;
    tick();
    i_wren = 1'b0; i_rden = 1'b0;
    m_dy = 8'h77;
    check("simul/dy", {24'd0, o_delay_y}, 32'h77);
    check("simul/wait", {31'd0, o_master_waitrequest}, 32'd0);
    nval = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_master_readdatavalid) nval++;
    end
    check("simul/valid_count", 32'(nval), 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [31:0] a;
      i_sts = 4'($urandom); i_linkup = 4'($urandom);
      i_dout_first = {$urandom, $urandom, $urandom, $urandom};
      i_dout_last  = {$urandom, $urandom, $urandom, $urandom};
      i_din_first  = {$urandom, $urandom, $urandom, $urandom};
      i_din_last   = {$urandom, $urandom, $urandom, $urandom};
      a = rand_addr();
      case ($urandom_range(0, 3))
        0: do_write(a, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    $sformatf("rnd%0d_wr@%08h", it, a));
        1: do_read(a, model_read(a), $sformatf("rnd%0d_rd@%08h", it, a));
        2: pulse_done(1'($urandom), 1'($urandom));
        default: tick();
      endcase
    end

    // Make every output non-zero, then reset during DECODE
    do_write(BASE + 32'h1000, 32'hA5A5_0001, 1'b0, 1'b0, "pre_rst/wr_cfg");
    do_write(BASE + 32'h1010, 32'h5A5A_0002, 1'b0, 1'b0, "pre_rst/rd_cfg");
    do_write(BASE + 32'h1004, 32'h1234_0003, 1'b0, 1'b0, "pre_rst/addr");
    do_write(BASE + 32'h2000, 32'h11, 1'b0, 1'b0, "pre_rst/dx");
    do_write(BASE + 32'h2004, 32'h22, 1'b0, 1'b0, "pre_rst/dy");
    do_write(BASE + 32'h2008, 32'h3333, 1'b0, 1'b0, "pre_rst/dz");
    do_read(BASE + 32'h2008, 32'h3333, "pre_rst/rd");
    i_wr_addr = BASE + 32'h1000; i_rden = 1'b1;
    tick();
    i_rden = 1'b0; avmm_rst = 1'b1;
    tick();
    avmm_rst = 1'b0;
    model_reset();
    check_all_zero("mid_read_rst");
    nval = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_master_readdatavalid) nval++;
    end
    check("mid_read_rst/valid_count", 32'(nval), 32'd0);
    do_read(BASE + 32'h1000, 32'h0, "post_rst/wr_cfg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
